// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: classifies segment lengths against unit windows and assembles 32-bit frames.
// Define NEC_EXT_ADDR_EN for extended NEC (16-bit address, no address inverse check).
module ir_nec_decoder #(
  parameter int   CNT_WIDTH  = 25,
  parameter int   UNIT       = 28125,
  parameter int   TOL_SHIFT  = 2,
  parameter int   TIMEOUT    = 600000,
  parameter logic MARK_LEVEL = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_edge,
  input  logic                 i_pulse,
  input  logic [CNT_WIDTH-1:0] i_cnt,
`ifdef NEC_EXT_ADDR_EN
  output logic [15:0]          o_addr,
`else
  output logic [7:0]           o_addr,
`endif
  output logic [7:0]           o_cmd,
  output logic                 o_frame_vld,
  output logic                 o_rpt,
  output logic                 o_err,
  output logic                 o_busy
);

`ifdef NEC_EXT_ADDR_EN
  localparam int AW = 16;
`else
  localparam int AW = 8;
`endif
  localparam int CW = CNT_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, LEAD_SP, BIT_MK, BIT_SP, STOP_MK, RPT_MK} state_t;

  state_t          r_state, w_nxt_state;
  logic [31:0]     r_shift, w_nxt_shift;
  logic [4:0]      r_bitcnt, w_nxt_bitcnt;
  logic            r_have, w_nxt_have;
  logic [AW-1:0]   r_addr, w_nxt_addr;
  logic [7:0]      r_cmd, w_nxt_cmd;
  logic            r_fv, w_nxt_fv;
  logic            r_rpt, w_nxt_rpt;
  logic            r_err, w_nxt_err;

  // Widened by one bit so nominal + tolerance never wraps.
  function automatic logic in_win(input logic [CNT_WIDTH-1:0] c, input int n);
    logic [CW-1:0] nom, tol, cx;
    nom = CW'(n * UNIT);
    tol = nom >> TOL_SHIFT;
    cx  = {1'b0, c};
    return (cx >= (nom - tol)) && (cx <= (nom + tol));
  endfunction

  logic w_w1, w_w3, w_w4, w_w8, w_w16, w_mark, w_space, w_timeout;
  assign w_w1      = in_win(i_cnt, 1);
  assign w_w3      = in_win(i_cnt, 3);
  assign w_w4      = in_win(i_cnt, 4);
  assign w_w8      = in_win(i_cnt, 8);
  assign w_w16     = in_win(i_cnt, 16);
  assign w_mark    = (i_pulse == MARK_LEVEL);
  assign w_space   = !w_mark;
  assign w_timeout = ({1'b0, i_cnt} >= CW'(TIMEOUT));

  logic [7:0]    w_b0, w_b1, w_b2, w_b3;
  logic          w_addr_ok, w_frame_ok;
  logic [AW-1:0] w_new_addr;
  assign w_b0 = r_shift[7:0];
  assign w_b1 = r_shift[15:8];
  assign w_b2 = r_shift[23:16];
  assign w_b3 = r_shift[31:24];
`ifdef NEC_EXT_ADDR_EN
  assign w_addr_ok  = 1'b1;
  assign w_new_addr = {w_b1, w_b0};
`else
  assign w_addr_ok  = (w_b1 == ~w_b0);
  assign w_new_addr = w_b0;
`endif
  assign w_frame_ok = w_addr_ok && (w_b3 == ~w_b2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_have   <= 1'b0;
      r_addr   <= '0;
      r_cmd    <= '0;
      r_fv     <= 1'b0;
      r_rpt    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_shift  <= w_nxt_shift;
      r_bitcnt <= w_nxt_bitcnt;
      r_have   <= w_nxt_have;
      r_addr   <= w_nxt_addr;
      r_cmd    <= w_nxt_cmd;
      r_fv     <= w_nxt_fv;
      r_rpt    <= w_nxt_rpt;
      r_err    <= w_nxt_err;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_shift  = r_shift;
    w_nxt_bitcnt = r_bitcnt;
    w_nxt_have   = r_have;
    w_nxt_addr   = r_addr;
    w_nxt_cmd    = r_cmd;
    w_nxt_fv     = 1'b0;
    w_nxt_rpt    = 1'b0;
    w_nxt_err    = 1'b0;
    if (i_rx_edge) begin
      w_nxt_state = IDLE;
      case (r_state)
        IDLE: if (w_mark && w_w16) w_nxt_state = LEAD_SP;
        LEAD_SP: begin
          if (w_space && w_w8) begin
            w_nxt_state  = BIT_MK;
            w_nxt_bitcnt = '0;
          end else if (w_space && w_w4) w_nxt_state = RPT_MK;
          else w_nxt_err = 1'b1;
        end
        BIT_MK: begin
          if (w_mark && w_w1) w_nxt_state = BIT_SP;
          else w_nxt_err = 1'b1;
        end
        BIT_SP: begin
          if (w_space && (w_w1 || w_w3)) begin
            w_nxt_shift  = {w_w3, r_shift[31:1]};
            w_nxt_bitcnt = r_bitcnt + 5'd1;
            w_nxt_state  = (r_bitcnt == 5'd31) ? STOP_MK : BIT_MK;
          end else w_nxt_err = 1'b1;
        end
        STOP_MK: begin
          if (w_mark && w_w1 && w_frame_ok) begin
            w_nxt_addr = w_new_addr;
            w_nxt_cmd  = w_b2;
            w_nxt_fv   = 1'b1;
            w_nxt_have = 1'b1;
          end else begin
            w_nxt_err = 1'b1;
            // A well-timed stop mark on a bad payload also forgets the previous frame.
            if (w_mark && w_w1) w_nxt_have = 1'b0;
          end
        end
        RPT_MK: begin
          if (w_mark && w_w1) w_nxt_rpt = r_have;
          else w_nxt_err = 1'b1;
        end
        default: w_nxt_state = IDLE;
      endcase
    end else if (r_state != IDLE && w_timeout) begin
      w_nxt_state = IDLE;
      w_nxt_err   = 1'b1;
      w_nxt_have  = 1'b0;
    end
  end

  assign o_addr      = r_addr;
  assign o_cmd       = r_cmd;
  assign o_frame_vld = r_fv;
  assign o_rpt       = r_rpt;
  assign o_err       = r_err;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Randomized bench for ir_nec_decoder: segment-level NEC grammar model, per-cycle compare.
// Honors NEC_EXT_ADDR_EN the same way as the design.
module tb_ir_nec_decoder;
  localparam int   CW   = 25;
  localparam int   UNIT = 100;
  localparam int   TOLS = 2;
  localparam int   TMO  = 6000;
  localparam logic MK   = 1'b0;
`ifdef NEC_EXT_ADDR_EN
  localparam int AW = 16;
`else
  localparam int AW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_edge = 1'b0;
  logic          pulse = 1'b1;
  logic [CW-1:0] cnt = '0;
  logic [AW-1:0] addr;
  logic [7:0]    cmd;
  logic          frame_vld, rpt, err, busy;

  ir_nec_decoder #(.CNT_WIDTH(CW), .UNIT(UNIT), .TOL_SHIFT(TOLS), .TIMEOUT(TMO), .MARK_LEVEL(MK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_edge(rx_edge), .i_pulse(pulse), .i_cnt(cnt),
    .o_addr(addr), .o_cmd(cmd), .o_frame_vld(frame_vld), .o_rpt(rpt), .o_err(err), .o_busy(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_idx counts accepted segments of the current frame (0 = idle).
  int            m_idx = 0;
  bit            m_rptmode = 0;
  logic [31:0]   m_bits = '0;
  bit            m_have = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_cmd = '0;
  bit            n_fv, n_rpt, n_err;
  logic          e_fv = 0, e_rpt = 0, e_err = 0, e_busy = 0;
  logic [AW-1:0] e_addr = '0;
  logic [7:0]    e_cmd = '0;

  function automatic bit win(input int len, input int n);
    int nom, tol;
    nom = n * UNIT;
    tol = nom >> TOLS;
    return (len >= nom - tol) && (len <= nom + tol);
  endfunction

  task automatic model_edge(input bit is_mark, input int len);
    bit ok;
    ok = 0;
    if (m_idx == 0) begin
      if (is_mark && win(len, 16)) m_idx = 1;
      return;
    end
    if (m_idx == 1) begin
      if (!is_mark && win(len, 8)) begin ok = 1; m_rptmode = 0; end
      else if (!is_mark && win(len, 4)) begin ok = 1; m_rptmode = 1; end
    end else if (m_rptmode) begin
      if (is_mark && win(len, 1)) begin
        n_rpt = m_have;
        m_idx = 0;
        return;
      end
    end else if (m_idx < 66) begin
      if (m_idx % 2 == 0) ok = is_mark && win(len, 1);
      else if (!is_mark && (win(len, 1) || win(len, 3))) begin
        ok = 1;
        m_bits[(m_idx - 3) / 2] = win(len, 3);
      end
    end else if (is_mark && win(len, 1)) begin
      bit aok;
`ifdef NEC_EXT_ADDR_EN
      aok = 1;
`else
      aok = (m_bits[15:8] == (8'hFF ^ m_bits[7:0]));
`endif
      m_idx = 0;
      if (aok && m_bits[31:24] == (8'hFF ^ m_bits[23:16])) begin
        m_addr = AW'(m_bits[AW-1:0]);
        m_cmd  = m_bits[23:16];
        m_have = 1;
        n_fv   = 1;
      end else begin
        m_have = 0;
        n_err  = 1;
      end
      return;
    end
    if (ok) m_idx++;
    else begin
      m_idx = 0;
      n_err = 1;
    end
  endtask

  task automatic step(input logic e, input logic p, input int c);
    rx_edge = e;
    pulse   = p;
    cnt     = c[CW-1:0];
    n_fv = 0; n_rpt = 0; n_err = 0;
    if (e) model_edge(p == MK, c);
    else if (m_idx != 0 && c >= TMO) begin
      n_err = 1; m_idx = 0; m_have = 0;
    end
    @(posedge clk); #1;
    e_fv = n_fv; e_rpt = n_rpt; e_err = n_err;
    e_busy = (m_idx != 0); e_addr = m_addr; e_cmd = m_cmd;
  endtask

  task automatic seg(input bit is_mark, input int len);
    int g;
    step(1'b1, is_mark ? MK : ~MK, len);
    g = $urandom_range(1, 3);
    for (int k = 1; k <= g; k++) step(1'b0, is_mark ? ~MK : MK, k);
  endtask

  // Segment list of the frame currently being built: units and a mark flag.
  int q_len[$];
  bit q_mk[$];

  task automatic build_frame(input logic [31:0] data);
    q_len.delete(); q_mk.delete();
    q_mk.push_back(1); q_len.push_back(16);
    q_mk.push_back(0); q_len.push_back(8);
    for (int b = 0; b < 32; b++) begin
      q_mk.push_back(1); q_len.push_back(1);
      q_mk.push_back(0); q_len.push_back(data[b] ? 3 : 1);
    end
    q_mk.push_back(1); q_len.push_back(1);
  endtask

  task automatic build_rpt();
    q_len.delete(); q_mk.delete();
    q_mk.push_back(1); q_len.push_back(16);
    q_mk.push_back(0); q_len.push_back(4);
    q_mk.push_back(1); q_len.push_back(1);
  endtask

  // pct: fixed scale in percent (0 = random jitter within +/-24%).
  task automatic send(input int pct);
    for (int i = 0; i < q_len.size(); i++) begin
      int s;
      s = (pct != 0) ? pct : 100 + $urandom_range(0, 48) - 24;
      seg(q_mk[i], q_len[i] * UNIT * s / 100);
    end
  endtask

  function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  always @(negedge clk) begin
    chk("frame_vld", frame_vld, e_fv);
    chk("rpt", rpt, e_rpt);
    chk("err", err, e_err);
    chk("busy", busy, e_busy);
    chk("addr", addr, e_addr);
    chk("cmd", cmd, e_cmd);
  end

  int n_fv_seen = 0, n_rpt_seen = 0, n_err_seen = 0;
  always @(negedge clk) begin
    n_fv_seen  += frame_vld;
    n_rpt_seen += rpt;
    n_err_seen += err;
  end

  task automatic do_reset();
    rst_n = 1'b0; rx_edge = 1'b0;
    m_idx = 0; m_have = 0; m_addr = '0; m_cmd = '0; m_bits = '0;
    e_fv = 0; e_rpt = 0; e_err = 0; e_busy = 0; e_addr = '0; e_cmd = '0;
    @(negedge clk);
    chk("rst_outputs", {addr, cmd, frame_vld, rpt, err, busy}, '0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int f0, r0, x0;
  task automatic snap(); f0 = n_fv_seen; r0 = n_rpt_seen; x0 = n_err_seen; endtask

  initial begin
    #1;
    do_reset();

    snap(); build_rpt(); send(100);
    chk("rpt_after_reset", n_rpt_seen - r0, 0);

    snap(); build_frame(32'hF708FB04); send(100);
    chk("frame1_vld", n_fv_seen - f0, 1);
    chk("frame1_addr", 32'(addr), 32'h04);
    chk("frame1_cmd", cmd, 8'h08);
    chk("model_addr_pin", 32'(m_addr), 32'h04);

    snap(); build_rpt(); send(100);
    chk("rpt_strobe", n_rpt_seen - r0, 1);
    chk("rpt_addr_kept", 32'(addr), 32'h04);

    snap(); build_frame(32'hF608FB33); send(100);
    chk("badcmd_err", n_err_seen - x0, 1);
    chk("badcmd_addr_kept", 32'(addr), 32'h04);
    snap(); build_rpt(); send(100);
    chk("rpt_after_bad", n_rpt_seen - r0, 0);

    snap(); build_frame(nec(8'h5A, 8'hC3)); send(124);
    chk("plus24_vld", n_fv_seen - f0, 1);
    chk("plus24_cmd", cmd, 8'hC3);
    snap(); build_frame(nec(8'hA5, 8'h3C)); send(76);
    chk("minus24_vld", n_fv_seen - f0, 1);
    chk("minus24_cmd", cmd, 8'h3C);

    snap(); build_frame(nec(8'h11, 8'h22)); q_len[2] = 0;
    for (int i = 0; i < 2; i++) seg(q_mk[i], q_len[i] * UNIT);
    seg(1, 130);
    chk("w130_err", n_err_seen - x0, 1);

    build_frame(nec(8'h77, 8'h66));
    for (int i = 0; i < 22; i++) seg(q_mk[i], q_len[i] * UNIT);
    for (int c = 1; c <= TMO; c++) begin
      step(1'b0, MK, c);
      if (c == TMO - 1) chk("tmo_early", {err, busy}, 2'b01);
    end
    chk("tmo_err", {err, busy}, 2'b10);

    build_frame(nec(8'h99, 8'h55));
    for (int i = 0; i < 30; i++) seg(q_mk[i], q_len[i] * UNIT);
    do_reset();
    snap(); send(100);
    chk("post_rst_vld", n_fv_seen - f0, 1);
    chk("post_rst_addr", 32'(addr), 32'h99);

`ifdef NEC_EXT_ADDR_EN
    snap(); build_frame(32'hF7081234); send(100);
    chk("ext_vld", n_fv_seen - f0, 1);
    chk("ext_addr", 32'(addr), 32'h1234);
`endif

    for (int t = 0; t < 120; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) build_rpt();
      else if (kind < 8) build_frame(nec(8'($urandom), 8'($urandom)));
      else build_frame($urandom);
      if ($urandom_range(0, 3) == 0) begin
        int ix;
        ix = $urandom_range(0, q_len.size() - 1);
        q_len[ix] = 0;
        q_len.push_back(0);
        q_mk.push_back(1);
        send(0);
        seg(q_mk[ix], $urandom_range(0, 2200));
      end else send(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
